idelay_load_arbiter: RTL and testbench

IDELAY_LOAD_ARBITER -- requirements
Module: idelay_load_arbiter

---
 rtl/idelay_load_arbiter_pkg.sv | 35 +++
 rtl/idelay_load_arbiter_if.sv | 33 +++
 rtl/idelay_load_arbiter_rr_arbiter.sv | 50 +++++
 rtl/idelay_load_arbiter.sv | 148 ++++++++++++++
 tb/tb_idelay_load_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/idelay_load_arbiter_pkg.sv
// rtl/idelay_load_arbiter_pkg.sv - shared types and helpers for the IDELAY load arbiter
// Purpose: tap width, settle-counter width, FSM state encoding and small
//          index/tap helper functions shared by the arbiter, its interface
//          and its round-robin sub-module.
// Ports:   none (package)
package idelay_load_arbiter_pkg;

  localparam int TAP_W    = 5;
  localparam int SETTLE_W = 4;

  typedef logic [TAP_W-1:0]    tap_t;
  typedef logic [SETTLE_W-1:0] settle_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  // (a + b) mod n for 0 <= a, b < n, without a divider.
  function automatic int wrap_add(int a, int b, int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

  // Saturate a requested tap at the highest legal tap value.
  function automatic tap_t clamp_tap(tap_t tap, int max_tap);
    if (int'(tap) > max_tap) return tap_t'(max_tap);
    return tap;
  endfunction

endpackage

// File: rtl/idelay_load_arbiter_if.sv
// rtl/idelay_load_arbiter_if.sv - request/load bus between IDELAY lanes and the load arbiter
// Purpose: bundles the per-lane request/tap inputs and the LD/CNTVALUEIN/ack
//          outputs of the arbiter.
// Signals: i_req[LANES]        per-lane load request (level, held until ack)
//          i_tap[LANES*5]      per-lane requested tap, lane k at [5k+4:5k]
//          o_ack[LANES]        one-cycle acknowledge to the served lane
//          o_ld[LANES]         one-hot LD pulse to the lane's IDELAY
//          o_cntvaluein[LANES*5] per-lane CNTVALUEIN, held between loads
//          o_busy              load sequence in progress
// Modports: master = requesters/IDELAY side, slave = arbiter side.
interface idelay_load_arbiter_if #(
  parameter int LANES = 8
);
  import idelay_load_arbiter_pkg::*;

  logic [LANES-1:0]       i_req;
  logic [LANES*TAP_W-1:0] i_tap;
  logic [LANES-1:0]       o_ack;
  logic [LANES-1:0]       o_ld;
  logic [LANES*TAP_W-1:0] o_cntvaluein;
  logic                   o_busy;

  modport master (
    output i_req, i_tap,
    input  o_ack, o_ld, o_cntvaluein, o_busy
  );

  modport slave (
    input  i_req, i_tap,
    output o_ack, o_ld, o_cntvaluein, o_busy
  );

endinterface

// File: rtl/idelay_load_arbiter_rr_arbiter.sv
// rtl/idelay_load_arbiter_rr_arbiter.sv - round-robin grant for the IDELAY load arbiter
// Purpose: picks the first requesting lane at or after the priority pointer;
//          the pointer moves to the lane after the grant when advance is high.
// Ports:   clk, rst_n    clock, asynchronous active-low reset (pointer -> 0)
//          req[LANES]    request vector
//          advance       consume the current grant and rotate priority
//          grant[LANES]  one-hot grant (all zero when no request)
//          grant_idx     index of the granted lane
module rr_arbiter #(
  parameter int LANES = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] req,
  input  logic             advance,
  output logic [LANES-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);
  import idelay_load_arbiter_pkg::*;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan lanes starting at the pointer; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      cand = IDX_W'(wrap_add(int'(ptr_q), i, LANES));
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= IDX_W'(wrap_add(int'(grant_idx), 1, LANES));
    end
  end

endmodule

// File: rtl/idelay_load_arbiter.sv
// rtl/idelay_load_arbiter.sv - shares one tap-load sequencer among LANES IDELAY lanes
// Purpose: grants one requesting lane round-robin, pulses its LD for one cycle
//          with the captured tap on its CNTVALUEIN, waits SETTLE_CYCLES idle
//          cycles, then acknowledges the lane for one cycle.
// Ports:   i_clk    sole clock (also the IDELAY C clock)
//          i_rst_n  asynchronous active-low reset
//          bus      idelay_load_arbiter_if.slave (i_req, i_tap, o_ack, o_ld,
//                   o_cntvaluein, o_busy); all outputs are registered
// Config:  IDELAY_TAP_CLAMP_EN - when defined, captured taps above MAX_TAP are
//          loaded as MAX_TAP; otherwise taps pass unmodified.
module idelay_load_arbiter #(
  parameter int LANES         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_TAP       = 31
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  idelay_load_arbiter_if.slave  bus
);
  import idelay_load_arbiter_pkg::*;

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end
  if (MAX_TAP < 0 || MAX_TAP > 31) begin : g_bad_max_tap
    $error("MAX_TAP must be in 0..31");
  end

  state_t                 state_q, state_d;
  settle_cnt_t            cnt_q, cnt_d;
  logic                   advance;
  logic [LANES-1:0]       grant_oh;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       lane_q;
  tap_t                   tap_sel;
  tap_t                   tap_load;
  logic [LANES-1:0]       ld_r;
  logic [LANES-1:0]       ack_r;
  logic                   busy_r;
  logic [LANES*TAP_W-1:0] cv_r;

  rr_arbiter #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .req       (bus.i_req),
    .advance   (advance),
    .grant     (grant_oh),
    .grant_idx (grant_idx)
  );

  always_comb begin
    tap_sel = '0;
    for (int k = 0; k < LANES; k++) begin
      if (grant_idx == IDX_W'(k)) tap_sel = bus.i_tap[k*TAP_W +: TAP_W];
    end
  end

`ifdef IDELAY_TAP_CLAMP_EN
  assign tap_load = clamp_tap(tap_sel, MAX_TAP);
`else
  assign tap_load = tap_sel;
`endif

  // Next-state logic. The grant is consumed only in IDLE, so request/tap
  // changes while a load is in flight cannot disturb it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.i_req) begin
          advance = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
        cnt_d   = settle_cnt_t'(SETTLE_CYCLES);
      end
      ST_SETTLE: begin
        // Counter holds the remaining settle cycles including this one.
        if (cnt_q <= settle_cnt_t'(1)) begin
          state_d = ST_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - settle_cnt_t'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs: LD and the lane's CNTVALUEIN are updated on the
  // grant edge so both are valid together throughout the LOAD cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ld_r   <= '0;
      ack_r  <= '0;
      busy_r <= 1'b0;
      cv_r   <= '0;
      lane_q <= '0;
    end else begin
      ld_r   <= '0;
      ack_r  <= '0;
      busy_r <= (state_d != ST_IDLE);
      if (advance) begin
        lane_q <= grant_idx;
        ld_r   <= grant_oh;
        for (int k = 0; k < LANES; k++) begin
          if (grant_idx == IDX_W'(k)) cv_r[k*TAP_W +: TAP_W] <= tap_load;
        end
      end
      if (state_q == ST_SETTLE && state_d == ST_ACK) begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_q == IDX_W'(k)) ack_r[k] <= 1'b1;
        end
      end
    end
  end

  assign bus.o_ld         = ld_r;
  assign bus.o_ack        = ack_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_cntvaluein = cv_r;

endmodule

// File: tb/tb_idelay_load_arbiter.sv
// tb/tb_idelay_load_arbiter.sv - randomized self-checking bench for idelay_load_arbiter
module tb_idelay_load_arbiter;

  localparam int L  = 8;
  localparam int S  = 4;
  localparam int MT = 20;

  logic clk;
  logic rst_n;

  idelay_load_arbiter_if #(.LANES(L)) bus ();

  idelay_load_arbiter #(
    .LANES         (L),
    .SETTLE_CYCLES (S),
    .MAX_TAP       (MT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requester state driven onto the bus
  logic [L-1:0] req_v;
  logic [4:0]   tap_v [L];
  logic [L-1:0] hold;
  bit           rand_mode;

  // Reference model: a load occupies a fixed timeline after its grant edge
  // (t=1 LD, t=2+S ACK, then one idle cycle before the next grant).
  int         m_t;
  int         m_g;
  int         m_ptr;
  logic [4:0] m_cv [L];

  // Observations
  int cyc;
  int ld_cyc  [L];
  int ack_cyc [L];
  int delay_ps [L];
  int ld_q [$];
  int ack_q [$];

  function automatic logic [4:0] m_clamp(logic [4:0] t);
`ifdef IDELAY_TAP_CLAMP_EN
    if (t > 5'(MT)) return 5'(MT);
`endif
    return t;
  endfunction

  task automatic apply_inputs();
    bus.i_req = req_v;
    for (int k = 0; k < L; k++) bus.i_tap[5*k +: 5] = tap_v[k];
  endtask

  task automatic m_reset();
    m_t   = -1;
    m_g   = 0;
    m_ptr = 0;
    for (int k = 0; k < L; k++) m_cv[k] = '0;
  endtask

  task automatic model_edge();
    if (m_t == 2 + S) begin
      m_t = -1;
    end else if (m_t >= 1) begin
      m_t++;
    end else if (req_v != '0) begin
      for (int i = L - 1; i >= 0; i--) begin
        if (req_v[(m_ptr + i) % L]) m_g = (m_ptr + i) % L;
      end
      m_ptr     = (m_g + 1) % L;
      m_cv[m_g] = m_clamp(tap_v[m_g]);
      m_t       = 1;
    end
  endtask

  task automatic step();
    logic [L-1:0]   e_ld, e_ack;
    logic [L*5-1:0] e_cv;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge();
    @(negedge clk);
    e_ld  = '0;
    e_ack = '0;
    if (m_t == 1)     e_ld[m_g]  = 1'b1;
    if (m_t == 2 + S) e_ack[m_g] = 1'b1;
    for (int k = 0; k < L; k++) e_cv[5*k +: 5] = m_cv[k];
    check_eq("o_ld", bus.o_ld, e_ld);
    check_eq("o_ack", bus.o_ack, e_ack);
    check_eq("o_busy", bus.o_busy, (m_t >= 1));
    check_eq("o_cntvaluein", bus.o_cntvaluein, e_cv);
    check_eq("ld_ack_exclusive", (bus.o_ld != '0) && (bus.o_ack != '0), 1'b0);
    for (int k = 0; k < L; k++) begin
      if (bus.o_ld[k]) begin
        ld_cyc[k]   = cyc + 1;
        ld_q.push_back(k);
        delay_ps[k] = 600 + 78 * int'(bus.o_cntvaluein[5*k +: 5]);
        if (rand_mode && !hold[k] && $urandom_range(0, 3) == 0) begin
          req_v[k] = 1'b0;
          tap_v[k] = 5'd5;
        end
      end
      if (bus.o_ack[k]) begin
        ack_cyc[k] = cyc + 1;
        ack_q.push_back(k);
        if (!hold[k]) req_v[k] = 1'b0;
      end
      if (rand_mode && !bus.o_ack[k]) begin
        if (!req_v[k] && $urandom_range(0, 3) == 0) begin
          req_v[k] = 1'b1;
          tap_v[k] = 5'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          tap_v[k] = 5'($urandom);
        end
      end
    end
    apply_inputs();
  endtask

  task automatic run_until_ack(input string tag, input int lane, input int budget);
    ack_cyc[lane] = -1;
    for (int i = 0; i < budget && ack_cyc[lane] < 0; i++) step();
    check_eq({tag, "_ack_seen"}, ack_cyc[lane] >= 0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (m_t >= 1 || req_v != '0); i++) step();
    check_eq("drain_idle", (m_t < 1) && (req_v == '0), 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, bus.o_busy, 1'b0);
    check_eq({tag, "_ld"},   bus.o_ld,   '0);
    check_eq({tag, "_ack"},  bus.o_ack,  '0);
    check_eq({tag, "_cv"},   bus.o_cntvaluein, '0);
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) step();
    check_reset_state("reset");
    rst_n = 1'b1;
  endtask

  int n0;

  initial begin
    rst_n     = 1'b0;
    req_v     = '0;
    hold      = '0;
    rand_mode = 1'b0;
    cyc       = 0;
    for (int k = 0; k < L; k++) begin
      tap_v[k] = '0; ld_cyc[k] = -1; ack_cyc[k] = -1; delay_ps[k] = 0;
    end
    apply_inputs();
    m_reset();
    #1;
    check_reset_state("por");
    @(negedge clk);
    hard_reset();

    // Single request: lane 2, tap 17
    req_v[2] = 1'b1; tap_v[2] = 5'd17; apply_inputs();
    n0 = cyc + 1;
    run_until_ack("single", 2, 40);
    check_eq("single_ld_cycle", ld_cyc[2], n0 + 1);
    check_eq("single_ack_cycle", ack_cyc[2], n0 + 2 + S);
    check_eq("single_cv", bus.o_cntvaluein[14:10], 5'd17);
    check_eq("single_delay_ps", delay_ps[2], 600 + 78 * 17);
    drain();

    // Contention from reset: lanes 0, 3, 7
    hard_reset();
    ack_q.delete();
    req_v[0] = 1'b1; tap_v[0] = 5'd3;
    req_v[3] = 1'b1; tap_v[3] = 5'd11;
    req_v[7] = 1'b1; tap_v[7] = 5'd19;
    apply_inputs();
    for (int i = 0; i < 60 && ack_q.size() < 3; i++) step();
    check_eq("contend_count", ack_q.size(), 3);
    if (ack_q.size() == 3) begin
      check_eq("contend_first", ack_q[0], 0);
      check_eq("contend_second", ack_q[1], 3);
      check_eq("contend_third", ack_q[2], 7);
    end
    check_eq("contend_gap_0_3", ack_cyc[3] - ack_cyc[0], 3 + S);
    check_eq("contend_gap_3_7", ack_cyc[7] - ack_cyc[3], 3 + S);
    drain();

    // Wrap/fairness: lane 7 was last granted; hold lanes 1 and 7
    ld_q.delete();
    hold = 8'b1000_0010;
    req_v[1] = 1'b1; tap_v[1] = 5'd7;
    req_v[7] = 1'b1; tap_v[7] = 5'd25;
    apply_inputs();
    for (int i = 0; i < 60 && ld_q.size() < 3; i++) step();
    check_eq("wrap_count", ld_q.size(), 3);
    if (ld_q.size() == 3) begin
      check_eq("wrap_first", ld_q[0], 1);
      check_eq("wrap_second", ld_q[1], 7);
      check_eq("wrap_third", ld_q[2], 1);
    end
    hold = '0;
    req_v[1] = 1'b0; req_v[7] = 1'b0; apply_inputs();
    drain();

    // Clamp behaviour on tap 31
    req_v[5] = 1'b1; tap_v[5] = 5'd31; apply_inputs();
    run_until_ack("clamp", 5, 40);
`ifdef IDELAY_TAP_CLAMP_EN
    check_eq("clamp_cv", bus.o_cntvaluein[29:25], 5'd20);
`else
    check_eq("clamp_cv", bus.o_cntvaluein[29:25], 5'd31);
`endif
    drain();

    // Request dropped after grant, tap changed to 5
    req_v[4] = 1'b1; tap_v[4] = 5'd9; apply_inputs();
    ld_cyc[4] = -1;
    for (int i = 0; i < 20 && ld_cyc[4] < 0; i++) step();
    check_eq("drop_ld_seen", ld_cyc[4] >= 0, 1'b1);
    req_v[4] = 1'b0; tap_v[4] = 5'd5; apply_inputs();
    run_until_ack("drop", 4, 40);
    check_eq("drop_cv", bus.o_cntvaluein[24:20], 5'd9);
    drain();

    // Same tap again still runs the full sequence
    req_v[4] = 1'b1; tap_v[4] = 5'd9; apply_inputs();
    n0 = cyc + 1;
    run_until_ack("same_tap", 4, 40);
    check_eq("same_tap_ld_cycle", ld_cyc[4], n0 + 1);
    check_eq("same_tap_ack_cycle", ack_cyc[4], n0 + 2 + S);
    drain();

    // Reset asserted mid-SETTLE, then the held request completes
    req_v[6] = 1'b1; tap_v[6] = 5'd12; apply_inputs();
    for (int i = 0; i < 20 && m_t != 3; i++) step();
    check_eq("midrst_in_settle", m_t, 3);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    check_reset_state("midrst");
    repeat (2) step();
    rst_n = 1'b1;
    run_until_ack("midrst_rereq", 6, 40);
    check_eq("midrst_cv", bus.o_cntvaluein[34:30], 5'd12);
    drain();

    // Randomized traffic against the model
    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
